dr_ald_divider_pipe: RTL and testbench

- Pipelined, dynamically truncated Mitchell-style approximate logarithmic divider for signed integers.
- It is the inverse counterpart of the team's DR-ALM multiplier: significands are subtracted in the log domain instead of added.
- Produces a signed fixed-point quotient with FRAC_BITS fractional bits.
- Sits on valid/ready streams between operand sources and downstream accumulators, with full throughput and backpressure.

---
 rtl/dr_ald_divider_pipe.sv | 120 ++++++++++++
 tb/tb_dr_ald_divider_pipe.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/dr_ald_divider_pipe.sv
// dr_ald_divider_pipe: 3-stage truncated Mitchell log-domain signed divider with valid/ready flow
module dr_ald_divider_pipe #(
  parameter int WIDTH      = 16,
  parameter int KEEP_WIDTH = 6,
  parameter int FRAC_BITS  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_valid,
  output logic                       i_ready,
  input  logic [WIDTH-1:0]           i_a,
  input  logic [WIDTH-1:0]           i_b,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic [WIDTH+FRAC_BITS:0]   o_q,
  output logic                       o_dz,
  output logic                       o_busy
);
  localparam int OUT_W = WIDTH + FRAC_BITS + 1;
  localparam int KW    = $clog2(WIDTH);
  localparam int EW    = KW + 2;
  localparam int SW    = EW + $clog2(FRAC_BITS + KEEP_WIDTH + 1) + 1;
  typedef struct packed {
    logic            v, sz, dz, za;
    logic [WIDTH-1:0] abs_a, abs_b;
    logic [KW-1:0]    ka, kb;
  } s1_t;
  typedef struct packed {
    logic                  v, sz, dz, za;
    logic [KEEP_WIDTH-1:0] d;
    logic [EW-1:0]         e;
  } s2_t;
  typedef struct packed {
    logic             v, dz;
    logic [OUT_W-1:0] q;
  } s3_t;
  s1_t s1_d, s1_q;
  s2_t s2_d, s2_q;
  s3_t s3_d, s3_q;
  logic ld1, ld2, ld3;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [KEEP_WIDTH-1:0] xa, xb;
  logic [KEEP_WIDTH:0] dd;
  logic [EW-1:0] e;
  logic [KEEP_WIDTH:0] m;
  logic [SW-1:0] sh;
  logic [OUT_W-1:0] mag, sat, qv;
  function automatic logic [KW-1:0] lod(input logic [WIDTH-1:0] v);
    lod = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) lod = KW'(i);
  endfunction
  // a stage loads when empty or when its current contents move on this cycle
  assign ld3     = ~s3_q.v | o_ready;
  assign ld2     = ~s2_q.v | ld3;
  assign ld1     = ~s1_q.v | ld2;
  assign i_ready = ld1;
  assign o_valid = s3_q.v;
  assign o_q     = s3_q.q;
  assign o_dz    = s3_q.dz;
  assign o_busy  = s1_q.v | s2_q.v | s3_q.v;
  assign abs_a = i_a[WIDTH-1] ? -i_a : i_a;
  assign abs_b = i_b[WIDTH-1] ? -i_b : i_b;
  // normalise so the leading one sits at the MSB, then keep the KEEP_WIDTH bits below it
  assign xa = KEEP_WIDTH'((s1_q.abs_a << (KW'(WIDTH-1) - s1_q.ka)) >> (WIDTH-1-KEEP_WIDTH));
  assign xb = KEEP_WIDTH'((s1_q.abs_b << (KW'(WIDTH-1) - s1_q.kb)) >> (WIDTH-1-KEEP_WIDTH));
  assign dd = {1'b0, xa} - {1'b0, xb};
  assign e  = {2'b00, s1_q.ka} - {2'b00, s1_q.kb} - EW'(dd[KEEP_WIDTH]);
  assign m   = {1'b1, s2_q.d};
  assign sh  = {{(SW-EW){s2_q.e[EW-1]}}, s2_q.e} + SW'(FRAC_BITS) - SW'(KEEP_WIDTH);
  assign mag = sh[SW-1] ? (OUT_W'(m) >> (-sh)) : (OUT_W'(m) << sh);
  assign sat = {1'b0, {(OUT_W-1){1'b1}}};
  assign qv  = s2_q.dz ? (s2_q.za ? '0 : s2_q.sz ? -sat : sat) : s2_q.za ? '0 : s2_q.sz ? -mag : mag;
  // S1: sign, magnitudes, zero flags and leading-one positions
  always_comb begin
    s1_d   = s1_q;
    s1_d.v = ld1 ? i_valid : s1_q.v;
    if (ld1 && i_valid) begin
      s1_d.sz    = i_a[WIDTH-1] ^ i_b[WIDTH-1];
      s1_d.dz    = ~|i_b;
      s1_d.za    = ~|i_a;
      s1_d.abs_a = abs_a;
      s1_d.abs_b = abs_b;
      s1_d.ka    = lod(abs_a);
      s1_d.kb    = lod(abs_b);
    end
  end
  // S2: log-domain significand difference and exponent with borrow
  always_comb begin
    s2_d   = s2_q;
    s2_d.v = ld2 ? s1_q.v : s2_q.v;
    if (ld2 && s1_q.v) begin
      s2_d.sz = s1_q.sz;
      s2_d.dz = s1_q.dz;
      s2_d.za = s1_q.za;
      s2_d.d  = dd[KEEP_WIDTH-1:0];
      s2_d.e  = e;
    end
  end
  // S3: antilog shift, sign and special-case selection; held while stalled
  always_comb begin
    s3_d   = s3_q;
    s3_d.v = ld3 ? s2_q.v : s3_q.v;
    if (ld3 && s2_q.v) begin
      s3_d.dz = s2_q.dz;
      s3_d.q  = qv;
    end
  end
  // pipeline registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end
endmodule

// File: tb/tb_dr_ald_divider_pipe.sv
// tb_dr_ald_divider_pipe: directed and reference-model checks of the log-domain divider pipe
module tb_dr_ald_divider_pipe;
  localparam int W  = 16;
  localparam int K  = 6;
  localparam int F  = 8;
  localparam int OW = W + F + 1;
  localparam longint SAT = (longint'(1) << (OW - 1)) - 1;
  logic clk = 1'b0;
  logic rst_n, i_valid, i_ready, o_valid, o_ready, o_dz, o_busy;
  logic [W-1:0] i_a, i_b;
  logic [OW-1:0] o_q;
  int n_chk = 0;
  int n_fail = 0;
  dr_ald_divider_pipe #(.WIDTH(W), .KEEP_WIDTH(K), .FRAC_BITS(F)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_a(i_a), .i_b(i_b),
    .o_valid(o_valid), .o_ready(o_ready), .o_q(o_q), .o_dz(o_dz), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic longint qs();
    return longint'($signed(o_q));
  endfunction
  function automatic int msb_pos(input int v);
    int p = 0;
    for (int i = 0; i < W; i++) if (((v >> i) & 1) != 0) p = i;
    return p;
  endfunction
  function automatic longint model(input int a, input int b, output bit dz);
    int aa, bb, ka, kb, xa, xb, d, br, m, e, sh;
    longint mag;
    dz = (b == 0);
    if (b == 0) return (a == 0) ? 0 : (a > 0) ? SAT : -SAT;
    if (a == 0) return 0;
    aa = (a < 0) ? -a : a;
    bb = (b < 0) ? -b : b;
    ka = msb_pos(aa);
    kb = msb_pos(bb);
    xa = ((aa << (W - 1 - ka)) >> (W - 1 - K)) & ((1 << K) - 1);
    xb = ((bb << (W - 1 - kb)) >> (W - 1 - K)) & ((1 << K) - 1);
    d  = xa - xb;
    br = (d < 0) ? 1 : 0;
    m  = (1 << K) + (d & ((1 << K) - 1));
    e  = ka - kb - br;
    sh = e + F - K;
    mag = (sh >= 0) ? (longint'(m) << sh) : (longint'(m) >> (-sh));
    return (((a < 0) ? 1 : 0) ^ ((b < 0) ? 1 : 0)) != 0 ? -mag : mag;
  endfunction
  task automatic run_one(input string tag, input int a, input int b, input longint eq, input bit edz);
    int lat;
    i_a = W'(a);
    i_b = W'(b);
    i_valid = 1'b1;
    o_ready = 1'b1;
    step();
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 6) begin
      step();
      lat++;
    end
    check({tag, "_lat"}, lat, 3);
    check({tag, "_q"}, qs(), eq);
    check({tag, "_dz"}, o_dz, edz);
    step();
  endtask
  int     da[9]  = '{100, -100, 64, 1, -32768, 5, -5, 0, 0};
  int     db[9]  = '{7, 7, -4, -32768, 1, 0, 0, 0, 9};
  longint dq[9]  = '{3712, -3712, -4096, 0, -8388608, 16777215, -16777215, 0, 0};
  bit     ddz[9] = '{0, 0, 0, 0, 0, 1, 1, 1, 0};
  int ra[20], rb[20];
  longint rq[20];
  bit rdz[20];
  initial begin
    logic [15:0] tmp;
    rst_n = 1'b0;
    i_valid = 1'b0;
    o_ready = 1'b1;
    i_a = '0;
    i_b = '0;
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_q", qs(), 0);
    check("rst_dz", o_dz, 0);
    check("rst_busy", o_busy, 0);
    #9 rst_n = 1'b1;
    step();
    check("rel_ready", i_ready, 1);
    for (int i = 0; i < 9; i++) run_one($sformatf("dir%0d", i), da[i], db[i], dq[i], ddz[i]);
    // backpressure: three fill the pipe, the fourth waits
    o_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      i_a = W'(da[j]);
      i_b = W'(db[j]);
      i_valid = 1'b1;
      check($sformatf("bp_rdy%0d", j), i_ready, (j < 3) ? 1 : 0);
      if (j < 3) step();
    end
    for (int s = 0; s < 2; s++) begin
      step();
      check("bp_hold_rdy", i_ready, 0);
      check("bp_hold_v", o_valid, 1);
      check("bp_hold_q", qs(), dq[0]);
      check("bp_busy", o_busy, 1);
    end
    o_ready = 1'b1;
    #1;
    check("bp_rdy_release", i_ready, 1);
    for (int j = 0; j < 4; j++) begin
      check($sformatf("bp_out_v%0d", j), o_valid, 1);
      check($sformatf("bp_out_q%0d", j), qs(), dq[j]);
      step();
      i_valid = 1'b0;
    end
    check("bp_drained", o_valid, 0);
    // back-to-back random stream against the reference model
    for (int i = 0; i < 20; i++) begin
      tmp = 16'($urandom);
      ra[i] = int'($signed(tmp));
      tmp = 16'($urandom);
      rb[i] = ($urandom_range(0, 7) == 0) ? 0 : int'($signed(tmp));
      rq[i] = model(ra[i], rb[i], rdz[i]);
    end
    for (int c = 0; c < 24; c++) begin
      if (c >= 3 && c < 23) begin
        check($sformatf("rnd_v%0d", c - 3), o_valid, 1);
        check($sformatf("rnd_q%0d", c - 3), qs(), rq[c - 3]);
        check($sformatf("rnd_dz%0d", c - 3), o_dz, rdz[c - 3]);
      end
      if (c == 1 || c == 2) check("rnd_fill", o_valid, 0);
      if (c == 22) check("rnd_busy_last", o_busy, 1);
      if (c == 23) begin
        check("rnd_busy_fall", o_busy, 0);
        check("rnd_empty", o_valid, 0);
      end
      if (c < 20) begin
        i_a = W'(ra[c]);
        i_b = W'(rb[c]);
        i_valid = 1'b1;
        check("rnd_rdy", i_ready, 1);
      end else i_valid = 1'b0;
      step();
    end
    // reset with two items in flight
    o_ready = 1'b0;
    i_a = W'(5);
    i_b = W'(0);
    i_valid = 1'b1;
    step();
    i_a = W'(100);
    i_b = W'(7);
    step();
    i_valid = 1'b0;
    step();
    check("pre_rst_v", o_valid, 1);
    check("pre_rst_dz", o_dz, 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_v", o_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_q", qs(), 0);
    check("arst_dz", o_dz, 0);
    #3 rst_n = 1'b1;
    step();
    check("post_rst_rdy", i_ready, 1);
    o_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      i_a = 16'($urandom);
      i_b = 16'($urandom);
      step();
      check("post_rst_v", o_valid, 0);
      check("post_rst_busy", o_busy, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
